// File: rtl/tune_sequencer_pkg.sv
// Shared definitions for tune_sequencer: FSM states, tune start addresses,
// ROM word layout and the built-in tune ROM image.
package tune_sequencer_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_PLAY,
        S_GAP,
        S_END
    } state_t;

    localparam int unsigned NUM_TUNES = 4;

    // ROM word layout: {midi, dur}
    localparam int unsigned MIDI_MSB = 15;
    localparam int unsigned MIDI_LSB = 8;
    localparam int unsigned DUR_MSB  = 7;
    localparam int unsigned DUR_LSB  = 0;

    localparam logic [7:0] MIDI_REST = 8'h00;
    localparam logic [7:0] DUR_TERM  = 8'h00;

    function automatic logic [7:0] tune_base(input logic [1:0] idx);
        case (idx)
            2'd0:    return 8'h00;
            2'd1:    return 8'h10;
            2'd2:    return 8'h20;
            default: return 8'hFD;
        endcase
    endfunction

    // Tune 3 runs to the last ROM word without a terminator.
    function automatic logic [15:0] rom_image(input logic [15:0] a);
        case (a)
            16'h0000: return 16'h4503;
            16'h0001: return 16'h0002;
            16'h0002: return 16'h4801;
            16'h0003: return 16'h0000;
            16'h0010: return 16'h3C02;
            16'h0011: return 16'h3E01;
            16'h0012: return 16'h0000;
            16'h0020: return 16'h4003;
            16'h0021: return 16'h4302;
            16'h0022: return 16'h0000;
            16'h00FD: return 16'h5002;
            16'h00FE: return 16'h5201;
            16'h00FF: return 16'h5402;
            default:  return 16'h0000;
        endcase
    endfunction

endpackage

// File: rtl/tune_sequencer_rom.sv
// Synchronous 2**ROM_AW x 16 tune ROM, one clock read latency.
// Contents are held as a case table so the ROM needs no init file.
module tune_sequencer_rom
    import tune_sequencer_pkg::*;
#(
    parameter int unsigned ROM_AW = 8
) (
    input  logic              clk12MHz,
    input  logic [ROM_AW-1:0] addr,
    output logic [15:0]       data
);

    always_ff @(posedge clk12MHz) begin
        data <= rom_image(16'(addr));
    end

endmodule

// File: rtl/tune_sequencer.sv
// Arbitrates four tune requesters and plays ROM note sequences on the MIDI bus.
// Optional build macro PREEMPT_EN: a higher-priority request aborts the current tune at the next tick.
module tune_sequencer
    import tune_sequencer_pkg::*;
#(
    parameter int unsigned CLK_HZ    = 12000000,
    parameter int unsigned TICK_HZ   = 64,
    parameter int unsigned ROM_AW    = 8,
    parameter int unsigned GAP_TICKS = 2
) (
    input  logic       clk12MHz,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       stop,
    output logic [7:0] midi,
    output logic       note_on,
    output logic       busy,
    output logic [1:0] tune_idx
);

    localparam int unsigned PRESC_DIV = CLK_HZ / TICK_HZ;
    localparam int unsigned PRESC_W   = (PRESC_DIV > 1) ? $clog2(PRESC_DIV) : 1;
    localparam logic [ROM_AW-1:0] ADDR_LAST = '1;

    state_t              state;
    state_t              state_next;
    logic [ROM_AW-1:0]   addr;
    logic [ROM_AW-1:0]   addr_next;
    logic [7:0]          cnt;
    logic [7:0]          cnt_next;
    logic [7:0]          midi_next;
    logic [1:0]          idx_next;
    logic [3:0]          pending;
    logic [3:0]          grant_clr;
    logic [3:0]          req_q;
    logic [3:0]          req_prev;
    logic [3:0]          req_edge;
    logic [3:0]          discard;
    logic [1:0]          grant;
    logic [3:0]          grant_oh;
    logic                take_grant;
    logic                preempt;
    logic                playing;
    logic                tick;
    logic [PRESC_W-1:0]  presc;
    logic [15:0]         rom_data;

    tune_sequencer_rom #(
        .ROM_AW (ROM_AW)
    ) u_rom (
        .clk12MHz (clk12MHz),
        .addr     (addr),
        .data     (rom_data)
    );

    assign tick     = (presc == PRESC_W'(PRESC_DIV - 1));
    assign req_edge = req_q & ~req_prev;
    assign playing  = (state == S_FETCH) || (state == S_LOAD) ||
                      (state == S_PLAY)  || (state == S_GAP);
    assign discard  = playing ? (4'b0001 << tune_idx) : 4'b0000;

    always_comb begin
        if (pending[0])      grant = 2'd0;
        else if (pending[1]) grant = 2'd1;
        else if (pending[2]) grant = 2'd2;
        else                 grant = 2'd3;
    end

    assign grant_oh = 4'b0001 << grant;

`ifdef PREEMPT_EN
    assign preempt = (|pending) && (grant < tune_idx);
`else
    assign preempt = 1'b0;
`endif

    always_ff @(posedge clk12MHz) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        addr_next  = addr;
        cnt_next   = cnt;
        midi_next  = midi;
        idx_next   = tune_idx;
        grant_clr  = '0;
        take_grant = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (|pending) take_grant = 1'b1;
            end
            S_END: begin
                if (|pending) take_grant = 1'b1;
                else          state_next = S_IDLE;
            end
            S_FETCH: state_next = S_LOAD;
            S_LOAD: begin
                if (rom_data[DUR_MSB:DUR_LSB] == DUR_TERM) begin
                    midi_next  = MIDI_REST;
                    state_next = S_END;
                end else begin
                    midi_next  = rom_data[MIDI_MSB:MIDI_LSB];
                    cnt_next   = rom_data[DUR_MSB:DUR_LSB];
                    state_next = S_PLAY;
                end
            end
            S_PLAY: begin
                if (tick) begin
                    if (preempt) begin
                        midi_next  = MIDI_REST;
                        take_grant = 1'b1;
                    end else if (cnt == 8'd1) begin
                        midi_next = MIDI_REST;
                        // The last ROM word ends the tune rather than wrapping the address.
                        if (addr == ADDR_LAST) begin
                            state_next = S_END;
                        end else begin
                            addr_next = addr + ROM_AW'(1);
                            if (GAP_TICKS > 0) begin
                                cnt_next   = 8'(GAP_TICKS);
                                state_next = S_GAP;
                            end else begin
                                state_next = S_FETCH;
                            end
                        end
                    end else begin
                        cnt_next = cnt - 8'd1;
                    end
                end
            end
            S_GAP: begin
                if (tick) begin
                    if (preempt)            take_grant = 1'b1;
                    else if (cnt == 8'd1)   state_next = S_FETCH;
                    else                    cnt_next   = cnt - 8'd1;
                end
            end
            default: state_next = S_IDLE;
        endcase
        if (take_grant) begin
            state_next = S_FETCH;
            addr_next  = ROM_AW'(tune_base(grant));
            idx_next   = grant;
            grant_clr  = grant_oh;
        end
        if (stop) begin
            state_next = S_IDLE;
            midi_next  = MIDI_REST;
        end
    end

    always_comb begin
        busy    = (state != S_IDLE);
        note_on = (state == S_PLAY) && (midi != MIDI_REST);
    end

    always_ff @(posedge clk12MHz) begin
        if (rst) begin
            addr     <= '0;
            cnt      <= '0;
            midi     <= MIDI_REST;
            tune_idx <= '0;
            pending  <= '0;
            presc    <= '0;
            req_q    <= '0;
            req_prev <= '0;
        end else begin
            addr     <= addr_next;
            cnt      <= cnt_next;
            midi     <= midi_next;
            tune_idx <= idx_next;
            req_q    <= req;
            // On stop, a key that rose this clock is absorbed so it cannot raise an edge later.
            req_prev <= stop ? req : req_q;
            pending  <= stop ? '0 : ((pending & ~grant_clr) | (req_edge & ~discard));
            presc    <= ((state_next != state) || tick) ? '0 : presc + PRESC_W'(1);
        end
    end

endmodule

// File: tb/tb_tune_sequencer.sv
// Randomized self-checking bench for tune_sequencer (4 clocks per tick, 1 gap tick).
// Expected output timelines are built per clock from the tune note lists.
module tb_tune_sequencer;

    localparam int DIV  = 4;
    localparam int GAPT = 1;

    logic       clk12MHz = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic       stop;
    logic [7:0] midi;
    logic       note_on;
    logic       busy;
    logic [1:0] tune_idx;

    always #5 clk12MHz = ~clk12MHz;

    tune_sequencer #(
        .CLK_HZ    (12000000),
        .TICK_HZ   (3000000),
        .ROM_AW    (8),
        .GAP_TICKS (GAPT)
    ) dut (
        .clk12MHz (clk12MHz),
        .rst      (rst),
        .req      (req),
        .stop     (stop),
        .midi     (midi),
        .note_on  (note_on),
        .busy     (busy),
        .tune_idx (tune_idx)
    );

    int checks = 0;
    int passes = 0;

    // Reference tune content: notes as (midi, ticks); tune 3 has no terminator.
    logic [7:0] t_midi [4][3] = '{'{8'h45, 8'h00, 8'h48}, '{8'h3C, 8'h3E, 8'h00},
                                  '{8'h40, 8'h43, 8'h00}, '{8'h50, 8'h52, 8'h54}};
    int         t_dur  [4][3] = '{'{3, 2, 1}, '{2, 1, 0}, '{3, 2, 0}, '{2, 1, 2}};
    int         t_len  [4]    = '{3, 2, 2, 3};
    bit         t_term [4]    = '{1'b1, 1'b1, 1'b1, 1'b0};

    logic [7:0] e_midi[$];
    logic       e_busy[$];
    logic [1:0] e_idx[$];
    bit         e_tick[$];
    logic [1:0] last_idx = 2'd0;

    logic [7:0] o_midi[$];
    logic       o_busy[$];
    logic [1:0] o_idx[$];
    logic       o_on[$];

    int         ev_step[$];
    logic [3:0] ev_req[$];
    logic       ev_stop[$];
    logic       ev_rst[$];

    task automatic push(input logic [7:0] m, input logic b, input bit tk);
        e_midi.push_back(m);
        e_busy.push_back(b);
        e_idx.push_back(last_idx);
        e_tick.push_back(tk);
    endtask

    task automatic push_idle(input int n);
        repeat (n) push(8'h00, 1'b0, 1'b0);
    endtask

    // Per note: fetch+load, the note, then the gap (skipped after a ROM-end note).
    task automatic push_tune(input int t);
        last_idx = 2'(t);
        for (int n = 0; n < t_len[t]; n++) begin
            repeat (2) push(8'h00, 1'b1, 1'b0);
            for (int c = 0; c < t_dur[t][n] * DIV; c++)
                push(t_midi[t][n], 1'b1, (c % DIV) == DIV - 1);
            if (t_term[t] || n != t_len[t] - 1)
                for (int c = 0; c < GAPT * DIV; c++)
                    push(8'h00, 1'b1, (c % DIV) == DIV - 1);
        end
        if (t_term[t]) repeat (3) push(8'h00, 1'b1, 1'b0);
        else           push(8'h00, 1'b1, 1'b0);
    endtask

    task automatic trunc(input int n);
        while (e_midi.size() > n) begin
            void'(e_midi.pop_back());
            void'(e_busy.pop_back());
            void'(e_idx.pop_back());
            void'(e_tick.pop_back());
        end
    endtask

    task automatic clear_exp();
        e_midi.delete();
        e_busy.delete();
        e_idx.delete();
        e_tick.delete();
    endtask

    task automatic add_ev(input int s, input logic [3:0] r, input logic sp, input logic rs);
        ev_step.push_back(s);
        ev_req.push_back(r);
        ev_stop.push_back(sp);
        ev_rst.push_back(rs);
    endtask

    task automatic run_steps(input int n);
        o_midi.delete();
        o_busy.delete();
        o_idx.delete();
        o_on.delete();
        for (int i = 0; i < n; i++) begin
            for (int k = 0; k < ev_step.size(); k++) begin
                if (ev_step[k] == i) begin
                    req  = ev_req[k];
                    stop = ev_stop[k];
                    rst  = ev_rst[k];
                end
            end
            @(posedge clk12MHz);
            #1;
            o_midi.push_back(midi);
            o_busy.push_back(busy);
            o_idx.push_back(tune_idx);
            o_on.push_back(note_on);
        end
        ev_step.delete();
        ev_req.delete();
        ev_stop.delete();
        ev_rst.delete();
    endtask

    task automatic test_reset();
        rst  = 1'b1;
        req  = 4'b0000;
        stop = 1'b0;
        repeat (2) @(posedge clk12MHz);
        #1;
        checks++;
        if (midi !== 8'h00) $display("FAIL reset_midi: got %h expected 00", midi);
        else passes++;
        checks++;
        if (note_on !== 1'b0) $display("FAIL reset_note_on: got %b expected 0", note_on);
        else passes++;
        checks++;
        if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy);
        else passes++;
        checks++;
        if (tune_idx !== 2'd0) $display("FAIL reset_tune_idx: got %0d expected 0", tune_idx);
        else passes++;
        rst = 1'b0;
        @(posedge clk12MHz);
        #1;
    endtask

    task automatic test_single_tune();
        int d = $urandom_range(0, 3);
        clear_exp();
        add_ev(d, 4'b0001, 1'b0, 1'b0);
        add_ev(d + 1 + $urandom_range(0, 5), 4'b0000, 1'b0, 1'b0);
        push_idle(d + 2);
        push_tune(0);
        push_idle(3);
        run_steps(e_midi.size());
        for (int i = 0; i < e_midi.size(); i++) begin
            checks++;
            if (o_midi[i] !== e_midi[i] || o_busy[i] !== e_busy[i] || o_idx[i] !== e_idx[i] ||
                o_on[i] !== (e_midi[i] != 8'h00))
                $display("FAIL single_tune step %0d: got midi=%h busy=%b idx=%0d on=%b expected midi=%h busy=%b idx=%0d on=%b",
                         i, o_midi[i], o_busy[i], o_idx[i], o_on[i], e_midi[i], e_busy[i], e_idx[i], e_midi[i] != 8'h00);
            else passes++;
        end
    endtask

    task automatic test_back_to_back();
        for (int it = 0; it < 4; it++) begin
            logic [3:0] mask = (it == 0) ? 4'b1010 : 4'($urandom_range(1, 15));
            int d = $urandom_range(0, 3);
            clear_exp();
            add_ev(d, mask, 1'b0, 1'b0);
            add_ev(d + 1 + $urandom_range(0, 3), 4'b0000, 1'b0, 1'b0);
            push_idle(d + 2);
            for (int t = 0; t < 4; t++) if (mask[t]) push_tune(t);
            push_idle(3);
            run_steps(e_midi.size());
            for (int i = 0; i < e_midi.size(); i++) begin
                checks++;
                if (o_midi[i] !== e_midi[i] || o_busy[i] !== e_busy[i] || o_idx[i] !== e_idx[i] ||
                    o_on[i] !== (e_midi[i] != 8'h00))
                    $display("FAIL back_to_back mask=%b step %0d: got midi=%h busy=%b idx=%0d on=%b expected midi=%h busy=%b idx=%0d on=%b",
                             mask, i, o_midi[i], o_busy[i], o_idx[i], o_on[i], e_midi[i], e_busy[i], e_idx[i], e_midi[i] != 8'h00);
                else passes++;
            end
        end
    endtask

    task automatic test_held_key();
        clear_exp();
        push_idle(2);
        push_tune(2);
        push_idle(6);
        add_ev(0, 4'b0100, 1'b0, 1'b0);
        add_ev(8, 4'b0000, 1'b0, 1'b0);
        add_ev($urandom_range(10, 13), 4'b0100, 1'b0, 1'b0);
        add_ev(e_midi.size() - 2, 4'b0000, 1'b0, 1'b0);
        run_steps(e_midi.size());
        for (int i = 0; i < e_midi.size(); i++) begin
            checks++;
            if (o_midi[i] !== e_midi[i] || o_busy[i] !== e_busy[i] || o_idx[i] !== e_idx[i] ||
                o_on[i] !== (e_midi[i] != 8'h00))
                $display("FAIL held_key step %0d: got midi=%h busy=%b idx=%0d on=%b expected midi=%h busy=%b idx=%0d on=%b",
                         i, o_midi[i], o_busy[i], o_idx[i], o_on[i], e_midi[i], e_busy[i], e_idx[i], e_midi[i] != 8'h00);
            else passes++;
        end
    endtask

    task automatic test_stop();
        int s = $urandom_range(5, 14);
        clear_exp();
        push_idle(2);
        push_tune(0);
        trunc(s);
        push_idle(24);
        add_ev(0, 4'b0001, 1'b0, 1'b0);
        add_ev(3, 4'b0000, 1'b0, 1'b0);
        add_ev(s, 4'b0010, 1'b1, 1'b0);
        add_ev(s + 1, 4'b0010, 1'b0, 1'b0);
        add_ev(s + 6, 4'b0000, 1'b0, 1'b0);
        run_steps(e_midi.size());
        for (int i = 0; i < e_midi.size(); i++) begin
            checks++;
            if (o_midi[i] !== e_midi[i] || o_busy[i] !== e_busy[i] || o_idx[i] !== e_idx[i] ||
                o_on[i] !== (e_midi[i] != 8'h00))
                $display("FAIL stop step %0d: got midi=%h busy=%b idx=%0d on=%b expected midi=%h busy=%b idx=%0d on=%b",
                         i, o_midi[i], o_busy[i], o_idx[i], o_on[i], e_midi[i], e_busy[i], e_idx[i], e_midi[i] != 8'h00);
            else passes++;
        end
    endtask

    task automatic test_reset_midnote();
        int s = $urandom_range(5, 14);
        clear_exp();
        push_idle(2);
        push_tune(2);
        trunc(s);
        last_idx = 2'd0;
        push_idle(6);
        push_tune(1);
        push_idle(3);
        add_ev(0, 4'b0100, 1'b0, 1'b0);
        add_ev(3, 4'b0000, 1'b0, 1'b0);
        add_ev(s, 4'b0000, 1'b0, 1'b1);
        add_ev(s + 1, 4'b0000, 1'b0, 1'b0);
        add_ev(s + 4, 4'b0010, 1'b0, 1'b0);
        add_ev(s + 6, 4'b0000, 1'b0, 1'b0);
        run_steps(e_midi.size());
        for (int i = 0; i < e_midi.size(); i++) begin
            checks++;
            if (o_midi[i] !== e_midi[i] || o_busy[i] !== e_busy[i] || o_idx[i] !== e_idx[i] ||
                o_on[i] !== (e_midi[i] != 8'h00))
                $display("FAIL reset_midnote step %0d: got midi=%h busy=%b idx=%0d on=%b expected midi=%h busy=%b idx=%0d on=%b",
                         i, o_midi[i], o_busy[i], o_idx[i], o_on[i], e_midi[i], e_busy[i], e_idx[i], e_midi[i] != 8'h00);
            else passes++;
        end
    endtask

    task automatic test_priority_wait();
        int p = $urandom_range(6, 12);
        clear_exp();
        push_idle(2);
        push_tune(3);
`ifdef PREEMPT_EN
        begin
            int t = -1;
            for (int e = 0; e < e_tick.size(); e++)
                if (t < 0 && e_tick[e] && e + 1 >= p + 2) t = e + 1;
            if (t >= 0) trunc(t);
        end
`endif
        push_tune(0);
        push_idle(3);
        add_ev(0, 4'b1000, 1'b0, 1'b0);
        add_ev(2, 4'b0000, 1'b0, 1'b0);
        add_ev(p, 4'b0001, 1'b0, 1'b0);
        add_ev(p + 2, 4'b0000, 1'b0, 1'b0);
        run_steps(e_midi.size());
        for (int i = 0; i < e_midi.size(); i++) begin
            checks++;
            if (o_midi[i] !== e_midi[i] || o_busy[i] !== e_busy[i] || o_idx[i] !== e_idx[i] ||
                o_on[i] !== (e_midi[i] != 8'h00))
                $display("FAIL priority_wait step %0d: got midi=%h busy=%b idx=%0d on=%b expected midi=%h busy=%b idx=%0d on=%b",
                         i, o_midi[i], o_busy[i], o_idx[i], o_on[i], e_midi[i], e_busy[i], e_idx[i], e_midi[i] != 8'h00);
            else passes++;
        end
    endtask

    initial begin
        test_reset();
        test_single_tune();
        test_back_to_back();
        test_held_key();
        test_stop();
        test_reset_midnote();
        test_priority_wait();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
